// File: rtl/pwm_multicanal.sv
// Multi-channel PWM generator. All channels share one counter and period.
// Each channel has a double-buffered threshold and polarity, and the new values take effect when the counter wraps.
module pwm_multicanal #(
    parameter int WIDTH = 12,
    parameter int N_CH  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_enable,
    input  logic [WIDTH-1:0]        i_period,
    input  logic                    i_load,
    input  logic [$clog2(N_CH)-1:0] i_ch_sel,
    input  logic [WIDTH-1:0]        i_umbral,
    input  logic [N_CH-1:0]         i_polarity,
    output logic [N_CH-1:0]         o_out,
    output logic [WIDTH-1:0]        o_count,
    output logic                    o_period_end
);

    localparam int SEL_W = $clog2(N_CH);
    localparam logic [SEL_W:0] N_CH_L = (SEL_W + 1)'(N_CH);

    logic [WIDTH-1:0] per_act;
    logic [N_CH-1:0]  pol_act;
    logic [WIDTH-1:0] thr_sh  [N_CH];
    logic [WIDTH-1:0] thr_act [N_CH];

    logic             wrap;
    logic             load_ok;
    logic [WIDTH-1:0] count_nxt;
    logic [N_CH-1:0]  out_nxt;

    function automatic logic pwm_level(input logic [WIDTH-1:0] k,
                                       input logic [WIDTH-1:0] thr,
                                       input logic             pol);
        return (k >= thr) ^ pol;
    endfunction

    assign wrap      = i_enable && (o_count == per_act);
    assign load_ok   = i_load && ({1'b0, i_ch_sel} < N_CH_L);
    assign count_nxt = wrap ? '0 : o_count + 1'b1;

    // On a wrap the output for count 0 must already use the incoming configuration.
    always_comb begin
        out_nxt = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (wrap)
                out_nxt[c] = pwm_level(count_nxt, thr_sh[c], i_polarity[c]);
            else
                out_nxt[c] = pwm_level(count_nxt, thr_act[c], pol_act[c]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            o_count      <= '0;
            o_period_end <= 1'b0;
            o_out        <= '0;
            per_act      <= '1;
            pol_act      <= '0;
            for (int c = 0; c < N_CH; c++) begin
                thr_sh[c]  <= '1;
                thr_act[c] <= '1;
            end
        end else begin
            o_period_end <= wrap;
            // The shadow write is ignored by the same-edge copy to thr_act.
            if (load_ok)
                thr_sh[i_ch_sel] <= i_umbral;
            if (i_enable) begin
                o_count <= count_nxt;
                o_out   <= out_nxt;
                if (wrap) begin
                    per_act <= i_period;
                    pol_act <= i_polarity;
                    for (int c = 0; c < N_CH; c++)
                        thr_act[c] <= thr_sh[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_multicanal.sv
// Directed bench for pwm_multicanal with a 4-channel main instance.
// A 3-channel instance checks that out-of-range channel selects are ignored.
module tb_pwm_multicanal;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_enable;
    logic [11:0] i_period;
    logic        i_load;
    logic [1:0]  i_ch_sel;
    logic [11:0] i_umbral;
    logic [3:0]  i_polarity;
    logic [3:0]  o_out;
    logic [11:0] o_count;
    logic        o_period_end;

    logic        load3;
    logic [1:0]  sel3;
    logic [11:0] umbral3;
    logic [2:0]  out3;
    logic [11:0] count3;
    logic        pe3;

    int n_total = 0;
    int n_bad   = 0;

    pwm_multicanal #(.WIDTH(12), .N_CH(4)) dut (
        .clock(clock), .reset(reset), .i_enable(i_enable), .i_period(i_period),
        .i_load(i_load), .i_ch_sel(i_ch_sel), .i_umbral(i_umbral),
        .i_polarity(i_polarity), .o_out(o_out), .o_count(o_count),
        .o_period_end(o_period_end)
    );

    pwm_multicanal #(.WIDTH(12), .N_CH(3)) dut3 (
        .clock(clock), .reset(reset), .i_enable(i_enable), .i_period(i_period),
        .i_load(load3), .i_ch_sel(sel3), .i_umbral(umbral3),
        .i_polarity(i_polarity[2:0]), .o_out(out3), .o_count(count3),
        .o_period_end(pe3)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        i_enable   = 1'b0;
        i_period   = 12'd9;
        i_load     = 1'b0;
        i_ch_sel   = 2'd0;
        i_umbral   = 12'd0;
        i_polarity = 4'b0000;
        load3      = 1'b0;
        sel3       = 2'd0;
        umbral3    = 12'd0;
        tick();
        tick();
        chk("rst_count", 32'(o_count), 32'd0);
        chk("rst_out", 32'(o_out), 32'd0);
        chk("rst_pe", 32'(o_period_end), 32'd0);

        // Load thresholds while disabled: ch0=3 ch1=0 ch2=12 ch3=5; dut3 ch0..2=2 then invalid sel 3.
        reset = 1'b0;
        i_load = 1'b1; load3 = 1'b1;
        i_ch_sel = 2'd0; i_umbral = 12'd3;  sel3 = 2'd0; umbral3 = 12'd2; tick();
        i_ch_sel = 2'd1; i_umbral = 12'd0;  sel3 = 2'd1; umbral3 = 12'd2; tick();
        i_ch_sel = 2'd2; i_umbral = 12'd12; sel3 = 2'd2; umbral3 = 12'd2; tick();
        i_ch_sel = 2'd3; i_umbral = 12'd5;  sel3 = 2'd3; umbral3 = 12'd0; tick();
        i_load = 1'b0; load3 = 1'b0;
        chk("dis_count", 32'(o_count), 32'd0);
        chk("dis_pe", 32'(o_period_end), 32'd0);

        // First period after reset runs to the all-ones terminal count.
        i_enable = 1'b1;
        tick();
        chk("first_count", 32'(o_count), 32'd1);
        chk("first_out", 32'(o_out), 32'd0);
        chk("first_pe", 32'(o_period_end), 32'd0);
        repeat (4094) tick();
        chk("max_count", 32'(o_count), 32'd4095);
        chk("max_out", 32'(o_out), 32'hF);
        chk("max_pe", 32'(o_period_end), 32'd0);
        chk("max_out3", 32'(out3), 32'h7);
        tick();

        // Periods A and B: period 10, ch0 low 3, ch1 always 1, ch2 always 0, ch3 low 5.
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 10; k++) begin
                chk("ab_count", 32'(o_count), 32'(k));
                chk("ab_out", 32'(o_out), 32'({(k >= 5), 1'b0, 1'b1, (k >= 3)}));
                chk("ab_pe", 32'(o_period_end), 32'(k == 0));
                chk("ab_out3", 32'(out3), 32'({3{(k >= 2)}}));
                tick();
            end
        end

        // Period C: mid-period load ch3=8 and polarity change must not affect this period.
        for (int k = 0; k < 10; k++) begin
            chk("c_count", 32'(o_count), 32'(k));
            chk("c_out", 32'(o_out), 32'({(k >= 5), 1'b0, 1'b1, (k >= 3)}));
            chk("c_pe", 32'(o_period_end), 32'(k == 0));
            i_load = 1'b0;
            if (k == 4) begin
                i_load = 1'b1; i_ch_sel = 2'd3; i_umbral = 12'd8;
                i_polarity = 4'b0110;
            end
            if (k == 9) begin
                i_load = 1'b1; i_ch_sel = 2'd0; i_umbral = 12'd7;
            end
            tick();
        end
        i_load = 1'b0;

        // Period D: ch0 still 3 (wrap-cycle load deferred), ch3=8, ch1/ch2 inverted.
        for (int k = 0; k < 10; k++) begin
            chk("d_count", 32'(o_count), 32'(k));
            chk("d_out", 32'(o_out), 32'({(k >= 8), 1'b0, 1'b1, (k >= 3)} ^ 4'b0110));
            chk("d_pe", 32'(o_period_end), 32'(k == 0));
            if (k == 5) begin
                i_enable = 1'b0;
                for (int h = 0; h < 4; h++) begin
                    tick();
                    chk("hold_count", 32'(o_count), 32'd5);
                    chk("hold_out", 32'(o_out), 32'b0101);
                    chk("hold_pe", 32'(o_period_end), 32'd0);
                end
                i_enable = 1'b1;
            end
            if (k == 6) i_period = 12'd4;
            tick();
        end

        // Periods E and F: period 5; ch0 thr 7 > period gives constant inactive.
        for (int p = 0; p < 2; p++) begin
            if (p == 1) i_period = 12'd9;
            for (int k = 0; k < 5; k++) begin
                chk("ef_count", 32'(o_count), 32'(k));
                chk("ef_out", 32'(o_out), 32'b0100);
                chk("ef_pe", 32'(o_period_end), 32'(k == 0));
                tick();
            end
        end

        // Period G: period 10 again, abort with reset at count 6.
        chk("g_count0", 32'(o_count), 32'd0);
        chk("g_pe0", 32'(o_period_end), 32'd1);
        repeat (6) tick();
        chk("g_count6", 32'(o_count), 32'd6);
        chk("g_out6", 32'(o_out), 32'b0100);
        reset = 1'b1;
        tick();
        chk("mrst_count", 32'(o_count), 32'd0);
        chk("mrst_out", 32'(o_out), 32'd0);
        chk("mrst_pe", 32'(o_period_end), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_count", 32'(o_count), 32'd1);
        chk("post_out", 32'(o_out), 32'd0);
        chk("post_pe", 32'(o_period_end), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
